// File: rtl/gbf_ddr_load_seq.sv
// gbf_ddr_load_seq
// DDR read sequencer for the GBF load path. Walks five regions in fixed order
// (CFG, ACT, FLGACT, WEI, FLGWEI), issuing single-outstanding INCR read bursts
// that never cross a 4 KB boundary, and forwards every returned beat
// downstream tagged with its region index.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse, accepted only in IDLE
//   region_base         : 5 x byte base address (BPB-aligned), region r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   region_beats        : 5 x beat count, 0 skips the region
//   busy, done, err     : status; err is a sticky rlast-mismatch flag
//   araddr/arlen/arvalid/arready : read address channel
//   rdata/rvalid/rlast/rready    : read data channel
//   out_data/out_valid/out_ready/out_region/out_last : downstream beat stream
module gbf_ddr_load_seq #(
  parameter int ADDR_WIDTH     = 32,
  parameter int PORT_DATAWIDTH = 128,
  parameter int TX_SIZE_WIDTH  = 20,
  parameter int BURST_LEN      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [5*ADDR_WIDTH-1:0]     region_base,
  input  logic [5*TX_SIZE_WIDTH-1:0]  region_beats,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [ADDR_WIDTH-1:0]       araddr,
  output logic [7:0]                  arlen,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [PORT_DATAWIDTH-1:0]   rdata,
  input  logic                        rvalid,
  input  logic                        rlast,
  output logic                        rready,
  output logic [PORT_DATAWIDTH-1:0]   out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2:0]                  out_region,
  output logic                        out_last
);

  localparam int NREG     = 5;
  localparam int BPB      = PORT_DATAWIDTH / 8;
  localparam int BPB_LOG2 = $clog2(BPB);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_ADDR, S_DATA, S_NXT, S_FIN} state_t;

  state_t                    state, state_nxt;
  logic [2:0]                region;
  logic [ADDR_WIDTH-1:0]     cfg_base  [NREG];
  logic [TX_SIZE_WIDTH-1:0]  cfg_beats [NREG];
  logic [ADDR_WIDTH-1:0]     addr;
  logic [TX_SIZE_WIDTH-1:0]  remaining;
  logic [8:0]                beat_cnt;

  logic [ADDR_WIDTH-1:0]     cur_base;
  logic [TX_SIZE_WIDTH-1:0]  cur_beats;
  logic [12:0]               to_4k, beats_to_4k, cap;
  logic [8:0]                len_c, burst_beats;
  logic                      start_ok, beat;

  assign start_ok = (state == S_IDLE) && start;

  // Configuration of the region currently being walked; region==5 reads as zero.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    cur_base  = '0;
    cur_beats = '0;
    for (int r = 0; r < NREG; r++) begin
      if (region == 3'(r)) begin
        cur_base  = cfg_base[r];
        cur_beats = cfg_beats[r];
      end
    end
  end

  // Burst length = min(BURST_LEN, remaining, beats left before the next 4 KB line).
  assign to_4k       = 13'h1000 - {1'b0, addr[11:0]};
  assign beats_to_4k = to_4k >> BPB_LOG2;
  assign cap         = (beats_to_4k < 13'(BURST_LEN)) ? beats_to_4k : 13'(BURST_LEN);
  assign len_c       = (remaining < TX_SIZE_WIDTH'(cap)) ? remaining[8:0] : cap[8:0];
  assign burst_beats = {1'b0, arlen} + 9'd1;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential logic uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_SEL;
      S_SEL: begin
        if (region == 3'd5)          state_nxt = S_FIN;
        else if (cur_beats == '0)    state_nxt = S_SEL;
        else                         state_nxt = S_ADDR;
      end
      S_ADDR: if (arvalid && arready) state_nxt = S_DATA;
      S_DATA: if (beat && beat_cnt == 9'd1)
                state_nxt = (remaining == '0) ? S_NXT : S_ADDR;
      S_NXT:  state_nxt = S_SEL;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs. The data path is a pure wire from slave to consumer while a
  // burst has beats outstanding; once beat_cnt is spent further beats stall.
  always_comb begin
    busy      = (state != S_IDLE) && (state != S_FIN);
    done      = (state == S_FIN);
    rready    = (state == S_DATA) && (beat_cnt != 9'd0) && out_ready;
    out_valid = (state == S_DATA) && (beat_cnt != 9'd0) && rvalid;
    beat      = rvalid && rready;
    out_last  = beat && (beat_cnt == 9'd1) && (remaining == '0);
  end

  assign out_data   = rdata;
  assign out_region = region;

  // Region configuration snapshot.
  always_ff @(posedge clk) begin
    // NOTE: the config registers have no reset; they are always written on an accepted start before being read.
    if (start_ok) begin
      for (int r = 0; r < NREG; r++) begin
        cfg_base[r]  <= region_base[r*ADDR_WIDTH +: ADDR_WIDTH];
        cfg_beats[r] <= region_beats[r*TX_SIZE_WIDTH +: TX_SIZE_WIDTH];
      end
    end
  end

  // Walk datapath. The first ADDR cycle registers the request, so arvalid,
  // araddr and arlen are flops held steady until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      region    <= '0;
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      araddr    <= '0;
      arlen     <= '0;
      arvalid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          region <= '0;
          err    <= 1'b0;
        end
        S_SEL: if (region != 3'd5) begin
          if (cur_beats == '0) begin
            region <= region + 3'd1;
          end else begin
            addr      <= cur_base;
            remaining <= cur_beats;
          end
        end
        S_ADDR: begin
          if (!arvalid) begin
            araddr  <= addr;
            arlen   <= 8'(len_c - 9'd1);
            arvalid <= 1'b1;
          end else if (arready) begin
            arvalid   <= 1'b0;
            addr      <= addr + (ADDR_WIDTH'(burst_beats) << BPB_LOG2);
            remaining <= remaining - TX_SIZE_WIDTH'(burst_beats);
            beat_cnt  <= burst_beats;
          end
        end
        S_DATA: if (beat) begin
          beat_cnt <= beat_cnt - 9'd1;
          if (rlast != (beat_cnt == 9'd1)) err <= 1'b1;
        end
        S_NXT: region <= region + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gbf_ddr_load_seq.sv
// Self-checking bench for gbf_ddr_load_seq: a reference model expands the
// region configuration into the expected burst and beat lists, a slave model
// answers the read bursts, and one monitor compares every handshake.
module tb_gbf_ddr_load_seq;

  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int TW  = 20;
  localparam int BL  = 16;
  localparam int BPB = DW / 8;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [5*AW-1:0] region_base;
  logic [5*TW-1:0] region_beats;
  logic            busy, done, err;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic            arvalid, arready;
  logic [DW-1:0]   rdata;
  logic            rvalid, rlast, rready;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready, out_last;
  logic [2:0]      out_region;

  always #5 clk = ~clk;

  gbf_ddr_load_seq #(.ADDR_WIDTH(AW), .PORT_DATAWIDTH(DW), .TX_SIZE_WIDTH(TW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .start(start), .region_base(region_base), .region_beats(region_beats),
    .busy(busy), .done(done), .err(err), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_region(out_region),
    .out_last(out_last)
  );

  typedef struct { logic [AW-1:0] addr; int len; } burst_t;
  typedef struct { int region; bit last; } beat_t;

  burst_t        exp_bursts[$];
  beat_t         exp_beats[$];
  logic [AW-1:0] ar_addr_log[$];
  int            ar_len_log[$];
  int            beat_reg_log[$];
  bit            beat_last_log[$];

  int n_cmp = 0, n_fail = 0;
  int done_count = 0, arvalid_seen = 0;
  bit stall_mode = 0, bad_rlast = 0;

  // slave state
  int            burst_left = 0, beat_idx = 0, serial = 0;
  bit            cur_bad = 0, beat_taken = 0, prev_wait = 0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_len;
  burst_t        eb;
  beat_t         et;

  logic [AW-1:0] t2_addr [4] = '{32'h0FC0, 32'h1000, 32'h1100, 32'h1200};
  int            t2_len  [4] = '{3, 15, 15, 3};

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Expand the configuration into bursts and beats from the splitting rules.
  task automatic build_model();
    exp_bursts.delete();
    exp_beats.delete();
    for (int r = 0; r < 5; r++) begin
      longint a   = region_base[r*AW +: AW];
      int     rem = int'(region_beats[r*TW +: TW]);
      while (rem > 0) begin
        int to4k = (4096 - int'(a % 4096)) / BPB;
        int len  = BL;
        if (rem < len)  len = rem;
        if (to4k < len) len = to4k;
        exp_bursts.push_back('{addr: a[AW-1:0], len: len});
        for (int i = 0; i < len; i++)
          exp_beats.push_back('{region: r, last: (rem == len) && (i == len - 1)});
        a   = (a + longint'(len * BPB)) & 64'hFFFF_FFFF;
        rem = rem - len;
      end
    end
  endtask

  task automatic clear_logs();
    ar_addr_log.delete();
    ar_len_log.delete();
    beat_reg_log.delete();
    beat_last_log.delete();
  endtask

  task automatic set_region(input int r, input logic [AW-1:0] base, input int beats);
    region_base[r*AW +: AW]  = base;
    region_beats[r*TW +: TW] = TW'(beats);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_seq(input string tag, input bit exp_err);
    int d0, cyc;
    build_model();
    clear_logs();
    d0 = done_count;
    pulse_start();
    #2;
    check({tag, "_busy_after_start"}, busy, 1'b1);
    check({tag, "_err_cleared"}, err, 1'b0);
    cyc = 0;
    while (done_count == d0 && cyc < 20000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    if (done_count == d0) fail_now({tag, "_done_timeout"});
    repeat (5) @(negedge clk);
    #2;
    check({tag, "_one_done"}, done_count, d0 + 1);
    check({tag, "_beats_left"}, exp_beats.size(), 0);
    check({tag, "_bursts_left"}, exp_bursts.size(), 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Slave + monitor: drive on the falling edge, sample 1 time unit later.
  always begin
    @(negedge clk);
    if (!rst) begin
      if (beat_taken) begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        burst_left--;
        beat_idx++;
        beat_taken = 0;
      end
      arready   = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rvalid && burst_left > 0 && (!stall_mode || $urandom_range(0, 1) == 1)) begin
        serial++;
        rvalid = 1'b1;
        rdata  = {32'(serial), 32'hDEAD_BEEF, ~32'(serial), 32'(serial * 3)};
        rlast  = cur_bad ? (beat_idx == 1) : (burst_left == 1);
      end
    end
    #1;
    if (rst) begin
      rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
      burst_left = 0; beat_idx = 0; beat_taken = 0; prev_wait = 0; cur_bad = 0;
    end else begin
      if (arvalid) arvalid_seen++;
      if (prev_wait) begin
        check("ar_hold_valid", arvalid, 1'b1);
        check("ar_hold_addr", araddr, prev_addr);
        check("ar_hold_len", arlen, prev_len);
      end
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
      if (arvalid && arready) begin
        ar_addr_log.push_back(araddr);
        ar_len_log.push_back(int'(arlen));
        if (exp_bursts.size() == 0) fail_now("extra_burst");
        else begin
          eb = exp_bursts.pop_front();
          check("araddr", araddr, eb.addr);
          check("arlen", arlen, eb.len - 1);
        end
        burst_left = int'(arlen) + 1;
        beat_idx   = 0;
        cur_bad    = bad_rlast;
        bad_rlast  = 0;
      end
      if (rvalid || out_valid)
        check("beat_agree", out_valid && out_ready, rvalid && rready);
      if (out_valid && out_ready) begin
        check("out_data", out_data, rdata);
        if (exp_beats.size() == 0) fail_now("extra_beat");
        else begin
          et = exp_beats.pop_front();
          check("out_region", out_region, et.region);
          check("out_last", out_last, et.last);
        end
        beat_reg_log.push_back(int'(out_region));
        beat_last_log.push_back(out_last);
        beat_taken = 1;
      end
      if (done) done_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, cyc, found, nlast;
    rst = 1'b1; start = 1'b0; region_base = '0; region_beats = '0;
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0; out_ready = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_out_region", out_region, 0);
    @(negedge clk);
    rst = 1'b0;

    // CFG only, 512 beats from 0
    set_region(0, 32'h0, 512);
    run_seq("cfg512", 1'b0);
    check("cfg512_nbursts", ar_addr_log.size(), 32);
    check("cfg512_first_addr", ar_addr_log[0], 32'h0);
    check("cfg512_last_addr", ar_addr_log[31], 32'h1F00);
    check("cfg512_last_len", ar_len_log[31], 15);
    check("cfg512_nbeats", beat_reg_log.size(), 512);
    nlast = 0;
    foreach (beat_last_log[i]) if (beat_last_log[i]) nlast++;
    check("cfg512_nlast", nlast, 1);
    check("cfg512_last_flag", beat_last_log[511], 1'b1);

    // ACT across a 4 KB line
    region_base = '0; region_beats = '0;
    set_region(1, 32'h0FC0, 40);
    run_seq("act4k", 1'b0);
    check("act4k_nbursts", ar_addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("act4k_addr%0d", i), ar_addr_log[i], t2_addr[i]);
      check($sformatf("act4k_len%0d", i), ar_len_log[i], t2_len[i]);
    end
    check("act4k_region", beat_reg_log[0], 1);

    // all regions, 3 beats each, random gaps and stalls
    set_region(0, 32'h0100, 3);
    set_region(1, 32'h2000, 3);
    set_region(2, 32'h0FF0, 3);
    set_region(3, 32'h3000, 3);
    set_region(4, 32'h4000, 3);
    stall_mode = 1;
    run_seq("stall", 1'b0);
    stall_mode = 0;
    check("stall_nbeats", beat_reg_log.size(), 15);
    for (int i = 0; i < 15 && i < beat_reg_log.size(); i++)
      check($sformatf("stall_region%0d", i), beat_reg_log[i], i / 3);

    // early rlast sets err; next start clears it
    region_base = '0; region_beats = '0;
    set_region(0, 32'h0, 4);
    bad_rlast = 1;
    run_seq("badrlast", 1'b1);
    run_seq("clear_err", 1'b0);

    // reset mid-DATA in WEI
    for (int r = 0; r < 5; r++) set_region(r, AW'(r * 32'h1000), 8);
    build_model();
    clear_logs();
    pulse_start();
    cyc = 0;
    while (!(beat_reg_log.size() > 0 && beat_reg_log[beat_reg_log.size()-1] == 3) && cyc < 2000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    if (cyc >= 2000) fail_now("wei_wait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("midrst_busy", busy, 1'b0);
    check("midrst_arvalid", arvalid, 1'b0);
    check("midrst_rready", rready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_seq("after_rst", 1'b0);
    check("after_rst_nbeats", beat_reg_log.size(), 40);
    check("after_rst_first_region", beat_reg_log[0], 0);

    // all zero: done after 7 cycles, start while busy and start during done ignored
    region_beats = '0;
    build_model();
    d0 = done_count;
    arvalid_seen = 0;
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    found = 0;
    while (found == 0 && cyc < 50) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      #2;
      cyc++;
      if (cyc == 3) start = 1'b1;
      if (cyc == 4) start = 1'b0;
      if (done) found = cyc;
    end
    check("zero_done_latency", found, 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("zero_one_done", done_count, d0 + 1);
    check("zero_no_ar", arvalid_seen, 0);
    check("zero_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gbf_ddr_load_seq.md
Name: gbf_ddr_load_seq

Overview:
- Synthesizable DDR read sequencer. Feeds the GBF load path from off-chip DDR.
- Walks five regions in fixed order: CFG, ACT, FLGACT, WEI, FLGWEI. Each region has its own base address and beat count.
- Issues AXI-style INCR read bursts, one outstanding at a time, and never lets a burst cross a 4 KB boundary.
- Forwards each returned beat downstream, tagged with its region index.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- PORT_DATAWIDTH, 128: read data beat width in bits; bytes per beat BPB = PORT_DATAWIDTH/8.
- TX_SIZE_WIDTH, 20: width of each per-region beat count.
- BURST_LEN, 16: maximum beats per burst. Must be a power of 2, ≤256.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- start, in, 1: one-cycle pulse. Begins the sequence; ignored while busy.
- region_base, in, 5*ADDR_WIDTH: byte base per region; region r at [r*ADDR_WIDTH +: ADDR_WIDTH]; must be BPB-aligned.
- region_beats, in, 5*TX_SIZE_WIDTH: beats per region; 0 means skip the region.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse when all regions are complete.
- err, out, 1: sticky rlast-mismatch flag; cleared by rst or an accepted start.
- araddr, out, ADDR_WIDTH: burst start address.
- arlen, out, 8: beats-1.
- arvalid, out, 1: address request valid.
- arready, in, 1: address accepted.
- rdata, in, PORT_DATAWIDTH: read beat data.
- rvalid, in, 1: read beat valid.
- rlast, in, 1: last beat of burst.
- rready, out, 1: equals out_ready while in DATA state, else 0.
- out_data, out, PORT_DATAWIDTH: equals rdata.
- out_valid, out, 1: equals rvalid while in DATA state, else 0.
- out_region, out, 3: region index of the current beat (0..4).
- out_last, out, 1: high on the final beat of a region.

Behaviour:
- Reset values: busy=0, done=0, err=0, arvalid=0, araddr=0, arlen=0, out_region=0; internal state=IDLE.
- Inputs region_base and region_beats are sampled only on an accepted start, into internal registers. Later input changes have no effect on the running sequence.
- FSM states:
  - IDLE: on start, latch config, region=0, clear err, go to SEL.
  - SEL: if region==5, go to FIN. Else if remaining beats for the region ==0, region++ and stay in SEL (one cycle per skipped region). Else set addr=base, go to ADDR.
  - ADDR: compute len = min(BURST_LEN, remaining, beats_to_4k), where beats_to_4k = (4096 - addr[11:0]) / BPB. Drive arvalid=1, arlen=len-1, araddr=addr. Hold all three stable until arready. On arready: addr += len*BPB, remaining -= len, beat_cnt = len, go to DATA.
  - DATA: each cycle with rvalid && rready is a beat: beat_cnt--. If rlast disagrees with (beat_cnt==1), set err; the beat still counts. When beat_cnt reaches 0: if remaining==0, go to NXT, else go to ADDR. Beats arriving after beat_cnt reaches 0 are not accepted (rready=0).
  - NXT: region++, go to SEL.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- arvalid is registered. It asserts the cycle after entering ADDR and deasserts in the cycle after the arready handshake.
- At most one burst is outstanding. No new address is issued until all beats of the current burst are received.
- out_last = beat accepted && beat_cnt==1 && remaining==0.
- Backpressure: the data path is combinational rvalid→out_valid, out_ready→rready, with no buffering.
- Address arithmetic wraps at 2^ADDR_WIDTH with no error.
- All regions zero: start → done pulse after exactly 7 cycles (IDLE→SEL×5 skips→FIN). No AR traffic.
- rst in any state returns to IDLE immediately. Any in-flight burst is abandoned; the system must also reset the slave.
- start while busy is ignored.
- start in the same cycle as done (FIN) is ignored; the FSM re-arms in IDLE.

Test Plan:
- CFG only, base 0x0000_0000, beats 512 (others 0) → 32 bursts, arlen=15, addresses 0x0, 0x100 … 0x1F00; 512 beats all with out_region=0; out_last only on beat 512; one done pulse; err=0.
- ACT base 0x0000_0FC0, beats 40 → bursts of 4 (crossing at 0x1000), 16, 16, 4; araddr 0xFC0, 0x1000, 0x1100, 0x1200; arlen 3, 15, 15, 3.
- All five regions at 3 beats each, random rvalid gaps and out_ready stalls (50%) → 15 beats in order, out_region sequence 0,0,0,1,1,1 … 4,4,4; no beat lost or duplicated; arvalid, araddr, arlen stable while arready=0.
- Slave asserts rlast on beat 2 of a 4-beat burst → err=1 stays set; the sequence still completes; the next accepted start clears err.
- rst asserted mid-DATA in the WEI region → next cycle busy=0, arvalid=0, rready=0. A new start runs the full sequence from the CFG region.
- All region_beats=0 → no arvalid; done exactly 7 cycles after start. A second start pulse while busy → ignored, with only one done.
